// File: rtl/ycbcr_pkg.sv
// Shared types and constants for the skin-detection capture front end.
package ycbcr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        FLUSH,
        DONE
    } sched_state_t;

    localparam int H_ACTIVE_720P = 1280;
    localparam int V_ACTIVE_720P = 720;

    // The RGB->YCbCr converter uses this same value for its pipeline depth.
    localparam int CONV_PIPE_LAT = 3;

endpackage

// File: rtl/ycbcr_frame_sched_meter.sv
// Per-line data-enable meter: measures each line's active width and flags
// widths that differ from the expected line length.
module de_line_meter
    import ycbcr_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int PIX_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             de_in,
    output logic             line_end,
    output logic [PIX_W-1:0] width,
    output logic             width_err
);

    logic             de_q;
    logic [PIX_W-1:0] pix_cnt;
    logic             pix_full;

    assign pix_full  = &pix_cnt;
    assign line_end  = en & de_q & ~de_in;
    assign width     = pix_cnt;

    // A pixel arriving while the counter is already full is a saturation error.
    assign width_err = (line_end & (pix_cnt != PIX_W'(H_ACTIVE)))
                     | (en & de_in & pix_full);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            de_q    <= 1'b0;
            pix_cnt <= '0;
        end else begin
            de_q <= en & de_in;
            if (line_end) begin
                pix_cnt <= '0;
            end else if (en && de_in && !pix_full) begin
                pix_cnt <= pix_cnt + PIX_W'(1);
            end
        end
    end

endmodule

// File: rtl/ycbcr_frame_sched.sv
// Frame-capture scheduler: enables the converter for exactly one frame after a
// start request, flushes its pipeline, and reports the measured geometry.
module ycbcr_frame_sched
    import ycbcr_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int PIPE_LAT = CONV_PIPE_LAT,
    parameter int PIX_W    = 12,
    parameter int LINE_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic              conv_ce,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic [PIX_W-1:0]  pix_count,
    output logic [LINE_W-1:0] line_count
);

    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    sched_state_t      state, state_next;
    logic              vsync_q;
    logic              frame_edge;
    logic              run_ok;
    logic              close_edge;
    logic              arm_to_run;
    logic              flush_last;
    logic [FW-1:0]     flush_cnt;
    logic              line_end;
    logic              width_err;
    logic [PIX_W-1:0]  width;
    logic              line_full;
    logic [LINE_W-1:0] lines_next;
    logic              unused_hsync;

    assign unused_hsync = hsync_in;
    assign frame_edge   = vsync_in & ~vsync_q;
    assign run_ok       = (state == RUN) & ~abort;
    assign close_edge   = run_ok & frame_edge;
    assign arm_to_run   = (state == ARM) & (state_next == RUN);
    assign flush_last   = (flush_cnt == FW'(PIPE_LAT - 1));
    assign line_full    = &line_count;
    assign lines_next   = line_count + LINE_W'(line_end & ~line_full);

    // Forcing de low on the closing edge makes a still-open line close there.
    de_line_meter #(
        .H_ACTIVE (H_ACTIVE),
        .PIX_W    (PIX_W)
    ) u_meter (
        .clk       (clk),
        .rst       (rst),
        .en        (state == RUN),
        .clr       (arm_to_run),
        .de_in     (de_in & ~close_edge),
        .line_end  (line_end),
        .width     (width),
        .width_err (width_err)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ARM;
            ARM:     if (abort) state_next = IDLE;
                     else if (frame_edge) state_next = RUN;
            RUN:     if (abort) state_next = IDLE;
                     else if (frame_edge) state_next = (PIPE_LAT == 0) ? DONE : FLUSH;
            FLUSH:   if (abort) state_next = IDLE;
                     else if (flush_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            vsync_q   <= 1'b0;
            flush_cnt <= '0;
            conv_ce   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            vsync_q   <= vsync_in;
            flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
            conv_ce   <= (state_next == RUN) || (state_next == FLUSH);
            busy      <= (state_next == ARM) || (state_next == RUN) || (state_next == FLUSH);
            done      <= (state_next == DONE);
        end
    end

    // Results only move while a capture is running, so an abort leaves them frozen.
    always_ff @(posedge clk) begin
        if (rst || arm_to_run) begin
            pix_count  <= '0;
            line_count <= '0;
            frame_err  <= 1'b0;
        end else if (run_ok) begin
            if (line_end) begin
                pix_count  <= width;
                line_count <= lines_next;
            end
            if (width_err || (line_end && line_full)
                || (close_edge && (lines_next != LINE_W'(V_ACTIVE)))) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule
